// File: rtl/mips_ldr_pkg.sv
// Shared types and constants for the mips32 program loader.
// Optional checksum byte per frame is enabled with `define MIPS_LDR_CKSUM_EN.
package mips_ldr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_COUNT,
      ST_DATA,
      ST_CKSUM,
      ST_RUN
   } ldr_state_e;

   localparam logic [7:0] CMD_IMEM_DEF = 8'hA5;
   localparam logic [7:0] CMD_DMEM_DEF = 8'h5A;
   localparam logic [7:0] CMD_RUN_DEF  = 8'hFF;

   // CMD, ADDR_HI, ADDR_LO, COUNT
   localparam int HDR_LEN = 4;

   // COUNT byte of zero encodes a full 256-word burst.
   function automatic logic [8:0] count_words(input logic [7:0] b);
      return (b == 8'h00) ? 9'd256 : {1'b0, b};
   endfunction

endpackage

// File: rtl/mips_ldr_asm.sv
// Byte-to-word assembler: shifts bytes in MSB first and flags the 4th byte.
// word_o is combinational so the top can register it together with the strobe.
module mips_ldr_asm (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic        word_done_o,
   output logic [31:0] word_o
);

   logic [1:0]  idx_q;
   logic [23:0] shift_q;

   // Byte index and the three leading bytes of the word in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q   <= 2'd0;
         shift_q <= 24'd0;
      end else if (byte_en_i) begin
         idx_q   <= idx_q + 2'd1;
         shift_q <= {shift_q[15:0], byte_i};
      end
   end

   assign word_done_o = byte_en_i && (idx_q == 2'd3);
   assign word_o      = {shift_q, byte_i};

endmodule

// File: rtl/mips_prog_loader.sv
// Framed byte-stream loader for mips32 instruction/data memories.
// Holds the core in reset until RUN. `define MIPS_LDR_CKSUM_EN adds a trailing
// XOR checksum byte to every frame. ADDR_W must lie in 9..16 (two address bytes).
module mips_prog_loader
   import mips_ldr_pkg::*;
#(
   parameter int         ADDR_W   = 10,
   parameter int         DATA_W   = 32,
   parameter logic [7:0] CMD_IMEM = CMD_IMEM_DEF,
   parameter logic [7:0] CMD_DMEM = CMD_DMEM_DEF,
   parameter logic [7:0] CMD_RUN  = CMD_RUN_DEF
) (
   input  logic              clk_x,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              imem_we,
   output logic              dmem_we,
   output logic              core_rst,
   output logic              busy,
   output logic              err
);

   ldr_state_e        state_q, state_d;
   logic [ADDR_W-9:0] hi_q, hi_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [8:0]        cnt_q, cnt_d;
   logic              dsel_q, dsel_d;
   logic              imem_we_q, imem_we_d, dmem_we_q, dmem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              err_q, err_d;
   logic              core_rst_q, core_rst_d;
`ifdef MIPS_LDR_CKSUM_EN
   logic [7:0]        cksum_q, cksum_d;
`endif

   logic        accept;
   logic        word_done;
   logic [31:0] word;

   assign in_ready = (state_q != ST_RUN);
   assign accept   = in_valid && in_ready;

   mips_ldr_asm u_asm (
      .clk_i       (clk_x),
      .rst_i       (rst),
      .byte_en_i   (accept && (state_q == ST_DATA)),
      .byte_i      (in_data),
      .word_done_o (word_done),
      .word_o      (word)
   );

   // Frame sequencing, address/count bookkeeping and write issue.
   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      dsel_d      = dsel_q;
      imem_we_d   = 1'b0;
      dmem_we_d   = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = err_q;
      core_rst_d  = core_rst_q;
`ifdef MIPS_LDR_CKSUM_EN
      cksum_d     = cksum_q;
`endif
      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               if (in_data == CMD_IMEM) begin
                  dsel_d  = 1'b0;
                  state_d = ST_ADDR_HI;
               end else if (in_data == CMD_DMEM) begin
                  dsel_d  = 1'b1;
                  state_d = ST_ADDR_HI;
               end else if (in_data == CMD_RUN) begin
                  // A RUN after an error is swallowed; the core stays held.
                  if (!err_q) begin
                     state_d    = ST_RUN;
                     core_rst_d = 1'b0;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            ST_ADDR_HI: begin
               hi_d    = in_data[ADDR_W-9:0];
               state_d = ST_ADDR_LO;
`ifdef MIPS_LDR_CKSUM_EN
               cksum_d = in_data;
`endif
            end
            ST_ADDR_LO: begin
               addr_d  = {hi_q, in_data};
               state_d = ST_COUNT;
`ifdef MIPS_LDR_CKSUM_EN
               cksum_d = cksum_q ^ in_data;
`endif
            end
            ST_COUNT: begin
               cnt_d   = count_words(in_data);
               state_d = ST_DATA;
`ifdef MIPS_LDR_CKSUM_EN
               cksum_d = cksum_q ^ in_data;
`endif
            end
            ST_DATA: begin
`ifdef MIPS_LDR_CKSUM_EN
               cksum_d = cksum_q ^ in_data;
`endif
               if (word_done) begin
                  imem_we_d   = !dsel_q;
                  dmem_we_d   = dsel_q;
                  mem_addr_d  = addr_q;
                  mem_wdata_d = word[DATA_W-1:0];
                  addr_d      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                  cnt_d       = cnt_q - 9'd1;
                  if (cnt_q == 9'd1) begin
`ifdef MIPS_LDR_CKSUM_EN
                     state_d = ST_CKSUM;
`else
                     state_d = ST_IDLE;
`endif
                  end
               end
            end
`ifdef MIPS_LDR_CKSUM_EN
            ST_CKSUM: begin
               // Writes already landed; a bad checksum only blocks RUN.
               if (in_data != cksum_q) err_d = 1'b1;
               state_d = ST_IDLE;
            end
`endif
            default: ;
         endcase
      end
   end

   // State and registered write-port outputs.
   always_ff @(posedge clk_x or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hi_q        <= '0;
         addr_q      <= '0;
         cnt_q       <= '0;
         dsel_q      <= 1'b0;
         imem_we_q   <= 1'b0;
         dmem_we_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         err_q       <= 1'b0;
         core_rst_q  <= 1'b1;
`ifdef MIPS_LDR_CKSUM_EN
         cksum_q     <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         dsel_q      <= dsel_d;
         imem_we_q   <= imem_we_d;
         dmem_we_q   <= dmem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         err_q       <= err_d;
         core_rst_q  <= core_rst_d;
`ifdef MIPS_LDR_CKSUM_EN
         cksum_q     <= cksum_d;
`endif
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign imem_we   = imem_we_q;
   assign dmem_we   = dmem_we_q;
   assign core_rst  = core_rst_q;
   assign err       = err_q;
   assign busy      = (state_q != ST_IDLE) && (state_q != ST_RUN);

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: directed frames push expected writes,
// a negedge monitor pops and compares on every strobe.
module tb_mips_prog_loader;

   logic        clk_x = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        imem_we, dmem_we, core_rst, busy, err;

   mips_prog_loader dut (
      .clk_x     (clk_x),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .imem_we   (imem_we),
      .dmem_we   (dmem_we),
      .core_rst  (core_rst),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk_x = ~clk_x;

   typedef struct packed {
      logic        dmem;
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t expq[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every strobe must match the oldest expected write.
   always @(negedge clk_x) begin
      wr_t e;
      if (!rst && (imem_we || dmem_we)) begin
         if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got imem=%b dmem=%b addr=%h data=%h expected none",
                     imem_we, dmem_we, mem_addr, mem_wdata);
         end else begin
            e = expq.pop_front();
            chk("wr_dmem", 32'(dmem_we), 32'(e.dmem));
            chk("wr_imem", 32'(imem_we), 32'(!e.dmem));
            chk("wr_addr", 32'(mem_addr), 32'(e.addr));
            chk("wr_data", mem_wdata, e.data);
         end
      end
   end

   task automatic exp_wr(input logic d, input logic [9:0] a, input logic [31:0] w);
      wr_t e;
      e.dmem = d; e.addr = a; e.data = w;
      expq.push_back(e);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk_x);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk_x);
   endtask

   task automatic gap();
      @(negedge clk_x);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_x);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk_x);
      chk("rst_core_rst", 32'(core_rst), 32'd1);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(negedge clk_x);
      chk("reset_core_rst", 32'(core_rst), 32'd1);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_imem_we", 32'(imem_we), 32'd0);
      chk("reset_dmem_we", 32'(dmem_we), 32'd0);
      chk("reset_mem_addr", 32'(mem_addr), 32'd0);
      chk("reset_mem_wdata", mem_wdata, 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      rst = 1'b0;

      // Single instruction word, with a stall after the header.
      exp_wr(1'b0, 10'h001, 32'hC0200001);
      send(8'hA5); send(8'h00); send(8'h01); send(8'h01);
      gap(); gap();
      chk("hdr_busy", 32'(busy), 32'd1);
      send(8'hC0); send(8'h20); send(8'h00); send(8'h01);
`ifdef MIPS_LDR_CKSUM_EN
      send(8'hE1);
`endif
      gap();
      chk("word_busy_after", 32'(busy), 32'd0);
      chk("word_core_rst", 32'(core_rst), 32'd1);

      // Data memory wrap from 0x3FF to 0x000, back to back.
      exp_wr(1'b1, 10'h3FF, 32'h11111111);
      exp_wr(1'b1, 10'h000, 32'h22222222);
      send(8'h5A); send(8'h03); send(8'hFF); send(8'h02);
      for (int i = 0; i < 4; i++) send(8'h11);
      for (int i = 0; i < 4; i++) send(8'h22);
`ifdef MIPS_LDR_CKSUM_EN
      send(8'hFE);
`endif
      gap();
      chk("wrap_busy_after", 32'(busy), 32'd0);
      chk("wrap_err", 32'(err), 32'd0);

      // Abort after two data bytes; partial word must be discarded.
      send(8'hA5); send(8'h00); send(8'h10); send(8'h01);
      send(8'hAA); send(8'hBB);
      @(negedge clk_x);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk_x);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_core_rst", 32'(core_rst), 32'd1);
      chk("abort_imem_we", 32'(imem_we), 32'd0);
      rst = 1'b0;
      exp_wr(1'b0, 10'h002, 32'h01020304);
      send(8'hA5); send(8'h00); send(8'h02); send(8'h01);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
`ifdef MIPS_LDR_CKSUM_EN
      send(8'h07);
`endif
      gap();

      // Unknown command sets err; RUN is then rejected.
      send(8'h33);
      gap();
      chk("badcmd_err", 32'(err), 32'd1);
      chk("badcmd_busy", 32'(busy), 32'd0);
      send(8'hFF);
      gap();
      chk("badrun_core_rst", 32'(core_rst), 32'd1);
      chk("badrun_in_ready", 32'(in_ready), 32'd1);
      chk("badrun_err", 32'(err), 32'd1);
      do_reset();

`ifdef MIPS_LDR_CKSUM_EN
      // Bad checksum: write still lands, err set, RUN rejected.
      exp_wr(1'b0, 10'h000, 32'hDEADBEEF);
      send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
      send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF); send(8'h00);
      gap();
      chk("cksum_bad_err", 32'(err), 32'd1);
      send(8'hFF);
      gap();
      chk("cksum_bad_core_rst", 32'(core_rst), 32'd1);
      do_reset();
      // Good checksum: err stays clear and RUN releases the core.
      exp_wr(1'b0, 10'h000, 32'hDEADBEEF);
      send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
      send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF); send(8'h23);
      gap();
      chk("cksum_good_err", 32'(err), 32'd0);
      send(8'hFF);
      gap();
      chk("cksum_good_core_rst", 32'(core_rst), 32'd0);
      do_reset();
`endif

      // Valid frame then RUN.
      exp_wr(1'b0, 10'h005, 32'h12345678);
      send(8'hA5); send(8'h00); send(8'h05); send(8'h01);
      send(8'h12); send(8'h34); send(8'h56); send(8'h78);
`ifdef MIPS_LDR_CKSUM_EN
      send(8'h0C);
`endif
      gap();
      chk("prerun_core_rst", 32'(core_rst), 32'd1);
      send(8'hFF);
      gap();
      chk("run_core_rst", 32'(core_rst), 32'd0);
      chk("run_in_ready", 32'(in_ready), 32'd0);
      chk("run_busy", 32'(busy), 32'd0);
      // Bytes offered in RUN are ignored.
      send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      gap();
      chk("run_hold_core_rst", 32'(core_rst), 32'd0);
      chk("run_hold_in_ready", 32'(in_ready), 32'd0);

      repeat (4) @(negedge clk_x);
      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
